// File: rtl/gfifo_pack_pkg.sv
// rtl/gfifo_pack_pkg.sv - shared widths, state encoding and slot type for the GFIFO message packer
package gfifo_pack_pkg;

   localparam int CBID_W = 20;
   localparam int LEN_W  = 12;
   localparam int WORD_W = 32;
   localparam int DATA_W = 512;
   localparam int WPB    = DATA_W / WORD_W;
   localparam int SLOT_W = $clog2(WPB + 1);

   typedef logic [SLOT_W-1:0] slot_t;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      SEND,
      WAIT_CO,
      DRAIN
   } state_t;

endpackage

// File: rtl/gfifo_beat_accum.sv
// rtl/gfifo_beat_accum.sv - 16-slot word accumulator that assembles one 512-bit beat
module gfifo_beat_accum
   import gfifo_pack_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [WORD_W-1:0] wr_data,
   output slot_t             words_in_beat,
   output logic [DATA_W-1:0] beat
);

   logic [WPB-1:0][WORD_W-1:0] words;
   slot_t                      slot;

   // Store each word at the current slot; clearing zeroes every slot so short beats are zero-padded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         words <= '0;
         slot  <= '0;
      end else if (clr) begin
         words <= '0;
         slot  <= '0;
      end else if (wr_en) begin
         words[slot[SLOT_W-2:0]] <= wr_data;
         slot                    <= slot + slot_t'(1);
      end
   end

   assign words_in_beat = slot;
   assign beat          = words;

endmodule

// File: rtl/gfifo_msg_packer.sv
// rtl/gfifo_msg_packer.sv - packs 32-bit callback words into 512-bit GFIFO beats with ci/co handshake
module gfifo_msg_packer
   import gfifo_pack_pkg::*;
#(
   parameter int CO_TIMEOUT = 4095
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sop,
   input  logic [CBID_W-1:0] in_cbid,
   input  logic [LEN_W-1:0]  in_msg_len,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_last,
   output logic              gf_ci,
   input  logic              gf_co,
   input  logic              gf_lock,
   output logic [CBID_W-1:0] gf_cbid,
   output logic [LEN_W-1:0]  gf_len,
   output logic [DATA_W-1:0] gf_idata,
   output logic              busy,
   output logic              err_len,
   output logic              err_timeout,
   input  logic              err_clr,
   output logic [15:0]       beat_cnt
);

   localparam int TMO_W = $clog2(CO_TIMEOUT + 1);

   state_t              state_q, state_d;
   logic [CBID_W-1:0]   cbid_q;
   logic [LEN_W-1:0]    remaining_q;
   logic                last_q, drain_q;
   logic                ready_q, ci_q;
   logic [TMO_W-1:0]    tmo_cnt;
   logic [15:0]         beat_cnt_q;
   logic                err_len_q, err_tmo_q;

   slot_t               wib, words_after;
   logic [DATA_W-1:0]   beat;
   logic [LEN_W-1:0]    msg_len_eff, rem_ref;
   logic                accept, beat_full, len_hit, tmo_hit;
   logic                acc_wr, acc_clr, load_msg, ci_set, co_done;
   logic                mark_last, mark_drain, len_err;

   gfifo_beat_accum u_accum (
      .clk           (clk),
      .rst_n         (rst_n),
      .clr           (acc_clr),
      .wr_en         (acc_wr),
      .wr_data       (in_data),
      .words_in_beat (wib),
      .beat          (beat)
   );

   // A zero length is treated as a one-word message.
   assign msg_len_eff = (in_msg_len == '0) ? LEN_W'(1) : in_msg_len;
   assign accept      = in_valid && ready_q;
   assign words_after = wib + slot_t'(1);
   // The SOP word is compared against the length arriving with it, later words against the latched count.
   assign rem_ref     = (state_q == IDLE) ? msg_len_eff : remaining_q;
   assign beat_full   = (words_after == slot_t'(WPB));
   assign len_hit     = (LEN_W'(words_after) == rem_ref);
   assign tmo_hit     = (state_q == WAIT_CO) && !gf_co && (tmo_cnt == TMO_W'(CO_TIMEOUT - 1));

   // Next-state and per-cycle control decisions.
   always_comb begin
      state_d    = state_q;
      acc_wr     = 1'b0;
      acc_clr    = 1'b0;
      load_msg   = 1'b0;
      ci_set     = 1'b0;
      co_done    = 1'b0;
      mark_last  = 1'b0;
      mark_drain = 1'b0;
      len_err    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (in_sop) begin
                  load_msg   = 1'b1;
                  acc_wr     = 1'b1;
                  mark_last  = in_last;
                  mark_drain = len_hit && !in_last;
                  len_err    = (len_hit != in_last);
                  state_d    = (in_last || beat_full || len_hit) ? SEND : FILL;
               end else begin
                  len_err = 1'b1;
               end
            end
         end
         FILL: begin
            if (accept) begin
               acc_wr     = 1'b1;
               mark_last  = in_last;
               mark_drain = len_hit && !in_last;
               len_err    = in_sop || (len_hit != in_last);
               if (in_last || beat_full || len_hit) begin
                  state_d = SEND;
               end
            end
         end
         SEND: begin
            if (!gf_lock) begin
               ci_set  = 1'b1;
               state_d = WAIT_CO;
            end
         end
         WAIT_CO: begin
            if (gf_co) begin
               co_done = 1'b1;
               acc_clr = 1'b1;
               if (drain_q) begin
                  state_d = DRAIN;
               end else if (last_q || (remaining_q == LEN_W'(wib))) begin
                  state_d = IDLE;
               end else begin
                  state_d = FILL;
               end
            end
         end
         DRAIN: begin
            if (accept && in_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; in_ready is registered from the next state so it is low while in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d == IDLE) || (state_d == FILL) || (state_d == DRAIN);
      end
   end

   // Message context, handshake request and beat counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cbid_q      <= '0;
         remaining_q <= '0;
         last_q      <= 1'b0;
         drain_q     <= 1'b0;
         ci_q        <= 1'b0;
         beat_cnt_q  <= '0;
      end else begin
         if (load_msg) begin
            cbid_q      <= in_cbid;
            remaining_q <= msg_len_eff;
         end else if (co_done) begin
            remaining_q <= remaining_q - LEN_W'(wib);
         end
         last_q  <= (last_q && !load_msg) || mark_last;
         drain_q <= (drain_q && !load_msg) || mark_drain;
         if (ci_set) begin
            ci_q <= 1'b1;
         end else if (co_done) begin
            ci_q <= 1'b0;
         end
         if (co_done) begin
            beat_cnt_q <= beat_cnt_q + 16'd1;
         end
      end
   end

   // Completion timeout counter and sticky errors; a new error event beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt   <= '0;
         err_len_q <= 1'b0;
         err_tmo_q <= 1'b0;
      end else begin
         if ((state_q == WAIT_CO) && !gf_co) begin
            if (tmo_cnt != TMO_W'(CO_TIMEOUT)) begin
               tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
         end else begin
            tmo_cnt <= '0;
         end
         err_len_q <= (err_len_q && !err_clr) || len_err;
         err_tmo_q <= (err_tmo_q && !err_clr) || tmo_hit;
      end
   end

   assign in_ready    = ready_q;
   assign gf_ci       = ci_q;
   assign gf_cbid     = cbid_q;
   assign gf_len      = remaining_q;
   assign gf_idata    = beat;
   assign busy        = (state_q != IDLE);
   assign err_len     = err_len_q;
   assign err_timeout = err_tmo_q;
   assign beat_cnt    = beat_cnt_q;

endmodule

// File: tb/tb_gfifo_msg_packer.sv
// tb/tb_gfifo_msg_packer.sv - randomized scoreboard bench for gfifo_msg_packer
module tb_gfifo_msg_packer;
   import gfifo_pack_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              in_sop = 1'b0;
   logic [CBID_W-1:0] in_cbid = '0;
   logic [LEN_W-1:0]  in_msg_len = '0;
   logic [WORD_W-1:0] in_data = '0;
   logic              in_last = 1'b0;
   logic              gf_ci;
   logic              gf_co = 1'b0;
   logic              gf_lock = 1'b0;
   logic [CBID_W-1:0] gf_cbid;
   logic [LEN_W-1:0]  gf_len;
   logic [DATA_W-1:0] gf_idata;
   logic              busy;
   logic              err_len;
   logic              err_timeout;
   logic              err_clr = 1'b0;
   logic [15:0]       beat_cnt;

   typedef struct {
      logic [CBID_W-1:0] cbid;
      logic [LEN_W-1:0]  len;
      logic [DATA_W-1:0] data;
   } beat_t;

   beat_t             sb_q[$];
   beat_t             cur;
   logic [WORD_W-1:0] msg_w[$];
   int                checks = 0;
   int                failures = 0;
   int                exp_beats = 0;
   int                co_lat = -1;
   bit                co_en = 1'b1;
   bit                stuck = 1'b0;
   logic              prev_ci = 1'b0;

   gfifo_msg_packer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_sop      (in_sop),
      .in_cbid     (in_cbid),
      .in_msg_len  (in_msg_len),
      .in_data     (in_data),
      .in_last     (in_last),
      .gf_ci       (gf_ci),
      .gf_co       (gf_co),
      .gf_lock     (gf_lock),
      .gf_cbid     (gf_cbid),
      .gf_len      (gf_len),
      .gf_idata    (gf_idata),
      .busy        (busy),
      .err_len     (err_len),
      .err_timeout (err_timeout),
      .err_clr     (err_clr),
      .beat_cnt    (beat_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      failures++;
      stuck = 1'b1;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   // Reference model: slice the words that fit the declared length into 16-word beats.
   function automatic void model_push(input logic [CBID_W-1:0] cb, input logic [LEN_W-1:0] ln, input int n);
      int    eff;
      int    nv;
      beat_t e;
      eff = (ln == 0) ? 1 : int'(ln);
      nv  = (n < eff) ? n : eff;
      for (int b = 0; b * WPB < nv; b++) begin
         e.cbid = cb;
         e.len  = LEN_W'(eff - b * WPB);
         e.data = '0;
         for (int k = 0; k < WPB; k++) begin
            if (b * WPB + k < nv) e.data[k*WORD_W +: WORD_W] = msg_w[b*WPB+k];
         end
         sb_q.push_back(e);
         exp_beats++;
      end
   endfunction

   // GFIFO responder: answer every outstanding ci with a one-cycle co after a latency.
   initial begin
      int lat;
      forever begin
         @(posedge clk);
         #1;
         if (gf_ci && co_en && !gf_co) begin
            lat = (co_lat < 0) ? int'($urandom_range(0, 6)) : co_lat;
            repeat (lat) begin
               @(posedge clk);
               #1;
            end
            gf_co = 1'b1;
            @(posedge clk);
            #1;
            gf_co = 1'b0;
         end
      end
   end

   // Monitor: compare each new beat with the scoreboard and check it is still held when co arrives.
   always @(negedge clk) begin
      if (gf_ci && !prev_ci) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=len%0d required=none", gf_len);
         end else begin
            cur = sb_q.pop_front();
            check("beat_cbid", DATA_W'(gf_cbid), DATA_W'(cur.cbid));
            check("beat_len", DATA_W'(gf_len), DATA_W'(cur.len));
            check("beat_idata", gf_idata, cur.data);
         end
      end
      if (gf_ci && gf_co) begin
         check("hold_len", DATA_W'(gf_len), DATA_W'(cur.len));
         check("hold_idata", gf_idata, cur.data);
      end
      prev_ci = gf_ci;
   end

   task automatic send_word(input logic [WORD_W-1:0] d, input bit sop, input bit last,
                            input logic [CBID_W-1:0] cb, input logic [LEN_W-1:0] ln);
      bit ok;
      if (stuck) return;
      in_valid   = 1'b1;
      in_data    = d;
      in_sop     = sop;
      in_last    = last;
      in_cbid    = cb;
      in_msg_len = ln;
      ok = 1'b0;
      for (int t = 0; t < 3000 && !ok; t++) begin
         ok = in_ready;
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_last  = 1'b0;
      if (!ok) bound_fail("in_ready_wait");
   endtask

   task automatic wait_idle();
      if (stuck) return;
      for (int t = 0; t < 3000 && busy; t++) @(negedge clk);
      if (busy) bound_fail("idle_wait");
   endtask

   task automatic wait_ci();
      if (stuck) return;
      for (int t = 0; t < 200 && !gf_ci; t++) @(negedge clk);
      if (!gf_ci) bound_fail("ci_wait");
   endtask

   task automatic send_msg(input logic [CBID_W-1:0] cb, input logic [LEN_W-1:0] ln, input int n, input bit wait_done);
      msg_w.delete();
      for (int i = 0; i < n; i++) msg_w.push_back($urandom);
      model_push(cb, ln, n);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         send_word(msg_w[i], i == 0, i == n - 1, cb, ln);
      end
      if (wait_done) wait_idle();
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int ln;
      int eff;
      int n;
      logic [CBID_W-1:0] cb;

      repeat (3) @(negedge clk);
      check("rst_in_ready", DATA_W'(in_ready), '0);
      check("rst_gf_ci", DATA_W'(gf_ci), '0);
      check("rst_gf_cbid", DATA_W'(gf_cbid), '0);
      check("rst_gf_len", DATA_W'(gf_len), '0);
      check("rst_gf_idata", gf_idata, '0);
      check("rst_busy", DATA_W'(busy), '0);
      check("rst_errs", DATA_W'({err_len, err_timeout}), '0);
      check("rst_beat_cnt", DATA_W'(beat_cnt), '0);
      rst_n = 1'b1;
      @(negedge clk);

      send_msg(20'h12345, 12'd3, 3, 1'b1);
      check("t1_beat_cnt", DATA_W'(beat_cnt), DATA_W'(exp_beats));
      check("t1_err_len", DATA_W'(err_len), '0);

      co_lat = 5;
      send_msg(20'h0abcd, 12'd40, 40, 1'b1);
      co_lat = -1;
      check("t2_beat_cnt", DATA_W'(beat_cnt), DATA_W'(exp_beats));

      gf_lock = 1'b1;
      send_msg(20'h00777, 12'd3, 3, 1'b0);
      repeat (10) @(negedge clk);
      check("lock_ci_low", DATA_W'(gf_ci), '0);
      check("lock_busy", DATA_W'(busy), DATA_W'(1));
      if (sb_q.size() != 0) check("lock_idata", gf_idata, sb_q[0].data);
      gf_lock = 1'b0;
      @(negedge clk);
      check("lock_ci_rise", DATA_W'(gf_ci), DATA_W'(1));
      gf_lock = 1'b1;
      wait_idle();
      gf_lock = 1'b0;
      check("lock_beat_cnt", DATA_W'(beat_cnt), DATA_W'(exp_beats));

      send_msg(20'h00055, 12'd5, 3, 1'b1);
      check("short_err_len", DATA_W'(err_len), DATA_W'(1));
      send_msg(20'h00056, 12'd7, 7, 1'b1);
      check("short_err_sticky", DATA_W'(err_len), DATA_W'(1));
      check("short_beat_cnt", DATA_W'(beat_cnt), DATA_W'(exp_beats));
      pulse_clr();
      check("short_err_clr", DATA_W'(err_len), '0);

      send_msg(20'h00099, 12'd2, 4, 1'b1);
      check("over_err_len", DATA_W'(err_len), DATA_W'(1));
      check("over_beat_cnt", DATA_W'(beat_cnt), DATA_W'(exp_beats));
      pulse_clr();

      send_word(32'hdeadbeef, 1'b0, 1'b1, 20'h1, 12'd1);
      @(negedge clk);
      check("stray_err_len", DATA_W'(err_len), DATA_W'(1));
      check("stray_busy", DATA_W'(busy), '0);
      check("stray_beat_cnt", DATA_W'(beat_cnt), DATA_W'(exp_beats));
      pulse_clr();

      for (int m = 0; m < 40; m++) begin
         cb  = CBID_W'($urandom);
         ln  = int'($urandom_range(0, 50));
         eff = (ln == 0) ? 1 : ln;
         n   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : eff;
         send_msg(cb, LEN_W'(ln), n, 1'b1);
         check("rand_err_len", DATA_W'(err_len), DATA_W'(n != eff));
         check("rand_beat_cnt", DATA_W'(beat_cnt), DATA_W'(exp_beats[15:0]));
         pulse_clr();
      end

      co_en = 1'b0;
      send_msg(20'h0f00d, 12'd1, 1, 1'b0);
      wait_ci();
      repeat (4000) @(negedge clk);
      check("tmo_not_yet", DATA_W'(err_timeout), '0);
      repeat (100) @(negedge clk);
      check("tmo_set", DATA_W'(err_timeout), DATA_W'(1));
      check("tmo_ci_high", DATA_W'(gf_ci), DATA_W'(1));
      co_en = 1'b1;
      wait_idle();
      check("tmo_beat_cnt", DATA_W'(beat_cnt), DATA_W'(exp_beats));
      check("tmo_sticky", DATA_W'(err_timeout), DATA_W'(1));
      pulse_clr();
      check("tmo_clr", DATA_W'(err_timeout), '0);

      co_en = 1'b0;
      send_msg(20'h0beef, 12'd4, 4, 1'b0);
      wait_ci();
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ci", DATA_W'(gf_ci), '0);
      check("mid_rst_ready", DATA_W'(in_ready), '0);
      check("mid_rst_cbid", DATA_W'(gf_cbid), '0);
      check("mid_rst_len", DATA_W'(gf_len), '0);
      check("mid_rst_idata", gf_idata, '0);
      check("mid_rst_busy", DATA_W'(busy), '0);
      check("mid_rst_beat_cnt", DATA_W'(beat_cnt), '0);
      @(negedge clk);
      rst_n = 1'b1;
      co_en = 1'b1;
      exp_beats = 0;
      @(negedge clk);
      check("sb_empty", DATA_W'(sb_q.size()), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
